// File: rtl/ifu_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_if
// Brief    : PC-in, memory read and decode-out handshakes of the fetch unit.
// Revision : 1.0
// ============================================================================
interface ifu_fetch_if #(
    parameter int BITWIDTH = 32
);
    logic                pc_valid;
    logic [BITWIDTH-1:0] pc;
    logic                pc_ready;
    logic                flush;

    logic                mem_req_valid;
    logic [BITWIDTH-1:0] mem_req_addr;
    logic                mem_req_ready;
    logic                mem_resp_valid;
    logic [31:0]         mem_resp_data;
    logic                mem_resp_err;

    logic                inst_valid;
    logic [31:0]         inst;
    logic [BITWIDTH-1:0] inst_pc;
    logic                inst_fault;
    logic                inst_ready;

    // The fetch unit is the master.
    modport master (
        input  pc_valid, pc, flush,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
        input  inst_ready,
        output pc_ready, mem_req_valid, mem_req_addr,
        output inst_valid, inst, inst_pc, inst_fault
    );

    modport slave (
        output pc_valid, pc, flush,
        output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
        output inst_ready,
        input  pc_ready, mem_req_valid, mem_req_addr,
        input  inst_valid, inst, inst_pc, inst_fault
    );
endinterface
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch
// Brief    : Single-outstanding instruction fetch with flush and timeout.
//            Optional macro IFU_ALIGN_CHECK_EN faults misaligned PCs.
// Revision : 1.0
// ============================================================================
module ifu_fetch #(
    parameter int          BITWIDTH       = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  wire logic   clk,
    input  wire logic   rst,
    ifu_fetch_if.master bus
);

    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [BITWIDTH-1:0] addr_q, addr_d;
    logic [31:0]         inst_q, inst_d;
    logic [BITWIDTH-1:0] inst_pc_q, inst_pc_d;
    logic                inst_fault_q, inst_fault_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                pc_ready_q, pc_ready_d;
    logic                mem_req_valid_q, mem_req_valid_d;
    logic                inst_valid_q, inst_valid_d;

    logic [TW-1:0]       timer_inc;
    logic                timeout_hit;

    // Timer saturates; timeout fires when the incremented count reaches the limit minus one.
    always_comb begin
        timer_inc   = (&timer_q) ? timer_q : timer_q + 1'b1;
        timeout_hit = (TIMEOUT_CYCLES != 0) &&
                      ((32'(timer_inc) + 32'd1) >= 32'(TIMEOUT_CYCLES));
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_fault_d = inst_fault_q;
        timer_d      = timer_q;

        case (state_q)
            S_IDLE: begin
                if (bus.pc_valid && !bus.flush) begin
                    addr_d = bus.pc;
`ifdef IFU_ALIGN_CHECK_EN
                    if (bus.pc[1:0] != 2'b00) begin
                        state_d      = S_OUT;
                        inst_d       = '0;
                        inst_fault_d = 1'b1;
                        inst_pc_d    = bus.pc;
                    end else begin
                        state_d = S_REQ;
                    end
`else
                    state_d = S_REQ;
`endif
                end
            end
            S_REQ: begin
                if (bus.mem_req_ready) begin
                    timer_d = '0;
                    state_d = bus.flush ? S_DRAIN : S_WAIT;
                end else if (bus.flush) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                timer_d = timer_inc;
                if (bus.flush) begin
                    // A response coinciding with the flush settles the request.
                    state_d = bus.mem_resp_valid ? S_IDLE : S_DRAIN;
                end else if (bus.mem_resp_valid) begin
                    state_d      = S_OUT;
                    inst_d       = bus.mem_resp_data;
                    inst_fault_d = bus.mem_resp_err;
                    inst_pc_d    = addr_q;
                end else if (timeout_hit) begin
                    state_d      = S_OUT;
                    inst_d       = '0;
                    inst_fault_d = 1'b1;
                    inst_pc_d    = addr_q;
                end
            end
            S_OUT: begin
                if (bus.flush || bus.inst_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                timer_d = timer_inc;
                if (bus.mem_resp_valid || timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        pc_ready_d      = (state_d == S_IDLE);
        mem_req_valid_d = (state_d == S_REQ);
        inst_valid_d    = (state_d == S_OUT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            inst_q          <= '0;
            inst_pc_q       <= '0;
            inst_fault_q    <= 1'b0;
            timer_q         <= '0;
            pc_ready_q      <= 1'b1;
            mem_req_valid_q <= 1'b0;
            inst_valid_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            inst_q          <= inst_d;
            inst_pc_q       <= inst_pc_d;
            inst_fault_q    <= inst_fault_d;
            timer_q         <= timer_d;
            pc_ready_q      <= pc_ready_d;
            mem_req_valid_q <= mem_req_valid_d;
            inst_valid_q    <= inst_valid_d;
        end
    end

    assign bus.pc_ready      = pc_ready_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = {addr_q[BITWIDTH-1:2], 2'b00};
    assign bus.inst_valid    = inst_valid_q;
    assign bus.inst          = inst_q;
    assign bus.inst_pc       = inst_pc_q;
    assign bus.inst_fault    = inst_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_fetch
// Brief    : Directed self-checking bench for ifu_fetch (TIMEOUT_CYCLES=4).
// Revision : 1.0
// ============================================================================
module tb_ifu_fetch;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    ifu_fetch_if #(.BITWIDTH(32)) bus ();

    ifu_fetch #(
        .BITWIDTH       (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fire_pc(input logic [31:0] addr);
        bus.pc_valid = 1'b1;
        bus.pc       = addr;
        step();
        bus.pc_valid = 1'b0;
    endtask

    initial begin
        bus.pc_valid       = 1'b0;
        bus.pc             = '0;
        bus.flush          = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.mem_resp_err   = 1'b0;
        bus.inst_ready     = 1'b0;

        // Reset state
        repeat (2) step();
        chk("rst_pc_ready", 32'(bus.pc_ready), 32'd1);
        chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_inst", bus.inst, 32'h0);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
        chk("rst_fault", 32'(bus.inst_fault), 32'd0);
        rst = 1'b1;
        step();

        // Basic fetch with minimum latency
        fire_pc(32'h8000_0000);
        chk("t1_req_valid", 32'(bus.mem_req_valid), 32'd1);
        chk("t1_req_addr", bus.mem_req_addr, 32'h8000_0000);
        chk("t1_pc_ready", 32'(bus.pc_ready), 32'd0);
        bus.mem_req_ready = 1'b1;
        step();
        chk("t1_req_dropped", 32'(bus.mem_req_valid), 32'd0);
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h0000_0413;
        step();
        bus.mem_resp_valid = 1'b0;
        chk("t1_inst_valid", 32'(bus.inst_valid), 32'd1);
        chk("t1_inst", bus.inst, 32'h0000_0413);
        chk("t1_inst_pc", bus.inst_pc, 32'h8000_0000);
        chk("t1_fault", 32'(bus.inst_fault), 32'd0);
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        chk("t1_done_valid", 32'(bus.inst_valid), 32'd0);
        chk("t1_done_pc_ready", 32'(bus.pc_ready), 32'd1);

        // Request and output backpressure
        fire_pc(32'h8000_0004);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_req_hold_valid", 32'(bus.mem_req_valid), 32'd1);
            chk("t2_req_hold_addr", bus.mem_req_addr, 32'h8000_0004);
        end
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h1234_5678;
        step();
        bus.mem_resp_valid = 1'b0;
        bus.pc_valid       = 1'b1;
        bus.pc             = 32'h8000_0100;
        for (int i = 0; i < 5; i++) begin
            chk("t2_out_valid", 32'(bus.inst_valid), 32'd1);
            chk("t2_out_inst", bus.inst, 32'h1234_5678);
            chk("t2_out_pc", bus.inst_pc, 32'h8000_0004);
            chk("t2_out_fault", 32'(bus.inst_fault), 32'd0);
            chk("t2_out_pc_ready", 32'(bus.pc_ready), 32'd0);
            step();
        end
        bus.pc_valid   = 1'b0;
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        chk("t2_done_valid", 32'(bus.inst_valid), 32'd0);

        // Flush in WAIT, late response discarded
        fire_pc(32'h8000_0008);
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        bus.flush         = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("t3_drain_valid", 32'(bus.inst_valid), 32'd0);
        chk("t3_drain_pc_ready", 32'(bus.pc_ready), 32'd0);
        step();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'hDEAD_BEEF;
        step();
        bus.mem_resp_valid = 1'b0;
        chk("t3_after_valid", 32'(bus.inst_valid), 32'd0);
        chk("t3_after_pc_ready", 32'(bus.pc_ready), 32'd1);
        fire_pc(32'h8000_0010);
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h00A0_0093;
        step();
        bus.mem_resp_valid = 1'b0;
        chk("t3_next_valid", 32'(bus.inst_valid), 32'd1);
        chk("t3_next_inst", bus.inst, 32'h00A0_0093);
        chk("t3_next_pc", bus.inst_pc, 32'h8000_0010);
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;

        // Bus error
        fire_pc(32'h8000_0014);
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h0000_0013;
        bus.mem_resp_err   = 1'b1;
        step();
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_err   = 1'b0;
        chk("t4_err_valid", 32'(bus.inst_valid), 32'd1);
        chk("t4_err_fault", 32'(bus.inst_fault), 32'd1);
        chk("t4_err_inst", bus.inst, 32'h0000_0013);
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;

        // Timeout: OUT four cycles after acceptance
        fire_pc(32'h8000_0018);
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t5_wait_valid", 32'(bus.inst_valid), 32'd0);
            chk("t5_wait_req", 32'(bus.mem_req_valid), 32'd0);
            step();
        end
        chk("t5_to_valid", 32'(bus.inst_valid), 32'd1);
        chk("t5_to_inst", bus.inst, 32'h0);
        chk("t5_to_fault", 32'(bus.inst_fault), 32'd1);
        chk("t5_to_pc", bus.inst_pc, 32'h8000_0018);
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;

        // Flush blocks acceptance in IDLE; flush withdraws a pending request
        bus.flush = 1'b1;
        fire_pc(32'h8000_0020);
        bus.flush = 1'b0;
        chk("t6_idle_flush_req", 32'(bus.mem_req_valid), 32'd0);
        chk("t6_idle_flush_ready", 32'(bus.pc_ready), 32'd1);
        fire_pc(32'h8000_0024);
        chk("t6_req_valid", 32'(bus.mem_req_valid), 32'd1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("t6_withdraw_req", 32'(bus.mem_req_valid), 32'd0);
        chk("t6_withdraw_ready", 32'(bus.pc_ready), 32'd1);

        // Asynchronous reset in WAIT, stray response afterwards
        fire_pc(32'h8000_001C);
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("t7_rst_pc_ready", 32'(bus.pc_ready), 32'd1);
        chk("t7_rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        step();
        rst = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'hCAFE_BABE;
        step();
        bus.mem_resp_valid = 1'b0;
        chk("t7_stray_valid", 32'(bus.inst_valid), 32'd0);
        chk("t7_stray_pc_ready", 32'(bus.pc_ready), 32'd1);
        chk("t7_stray_inst", bus.inst, 32'h0);

        // Misaligned PC
        fire_pc(32'h8000_0002);
`ifdef IFU_ALIGN_CHECK_EN
        chk("t8_mis_req", 32'(bus.mem_req_valid), 32'd0);
        chk("t8_mis_valid", 32'(bus.inst_valid), 32'd1);
        chk("t8_mis_fault", 32'(bus.inst_fault), 32'd1);
        chk("t8_mis_inst", bus.inst, 32'h0);
        chk("t8_mis_pc", bus.inst_pc, 32'h8000_0002);
`else
        chk("t8_req_valid", 32'(bus.mem_req_valid), 32'd1);
        chk("t8_req_addr", bus.mem_req_addr, 32'h8000_0000);
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h0000_0297;
        step();
        bus.mem_resp_valid = 1'b0;
        chk("t8_valid", 32'(bus.inst_valid), 32'd1);
        chk("t8_inst_pc", bus.inst_pc, 32'h8000_0002);
        chk("t8_fault", 32'(bus.inst_fault), 32'd0);
        chk("t8_inst", bus.inst, 32'h0000_0297);
`endif
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        chk("t8_done_valid", 32'(bus.inst_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit directly downstream of the PC register.
- Accepts a fetch address from the PC stage via valid/ready and issues one word read on the instruction memory port.
- Returns the instruction word, its PC and a fault flag to decode via valid/ready.
- Single outstanding request; supports flush on redirect (branch/trap) and a response timeout.

Parameters:
- BITWIDTH, 32, address/PC width.
- TIMEOUT_CYCLES, 255, response wait limit in cycles after request acceptance; 0 disables the timeout.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset; asserted when 0.
- pc_valid  input  1  upstream PC is a valid fetch address.
- pc  input  BITWIDTH  fetch address.
- pc_ready  output  1  IFU accepts the PC. Fire = pc_valid & pc_ready.
- flush  input  1  redirect; abandon the current fetch.
- mem_req_valid  output  1  read request valid.
- mem_req_addr  output  BITWIDTH  read address.
- mem_req_ready  input  1  memory accepts the request.
- mem_resp_valid  input  1  one-cycle response pulse, one per accepted request.
- mem_resp_data  input  32  instruction word.
- mem_resp_err  input  1  access error with the response.
- inst_valid  output  1  instruction valid to decode.
- inst  output  32  instruction word.
- inst_pc  output  BITWIDTH  PC of inst.
- inst_fault  output  1  fetch fault (bus error, timeout, misalignment).
- inst_ready  input  1  decode accepts the instruction.

Behaviour:
- All outputs come from registered state. While rst=0:
  - state=IDLE;
  - addr_q, inst, inst_pc, inst_fault and the timer are all 0;
  - pc_ready=1; mem_req_valid=0; inst_valid=0.
  - Reset mid-transaction abandons the fetch; a later stray mem_resp_valid is ignored.
- States are IDLE, REQ, WAIT, OUT, DRAIN.
- IDLE:
  - pc_ready=1.
  - On pc fire with flush=0: addr_q<=pc, go to REQ.
  - flush=1 blocks acceptance; stay in IDLE.
- REQ:
  - mem_req_valid=1; mem_req_addr=addr_q, held stable.
  - mem_req_ready=1 and flush=0: go to WAIT, timer<=0.
  - mem_req_ready=1 and flush=1 in the same cycle: go to DRAIN, timer<=0.
  - mem_req_ready=0 and flush=1: withdraw the request, go to IDLE.
- WAIT:
  - timer increments each cycle.
  - mem_resp_valid with flush=0: inst<=mem_resp_data, inst_fault<=mem_resp_err, inst_pc<=addr_q, go to OUT.
  - flush=1 (including the same cycle as the response): go to DRAIN, or to IDLE if the response arrives in that same cycle.
  - Timeout: timer reaches TIMEOUT_CYCLES-1 with no response (TIMEOUT_CYCLES≠0). Go to OUT with inst=0 and inst_fault=1.
- OUT:
  - inst_valid=1; inst, inst_pc and inst_fault are held stable until inst_ready=1.
  - inst_ready=1: go to IDLE. A new PC can fire on the following cycle.
  - flush=1: inst_valid drops next cycle, go to IDLE; flush has priority over inst_ready.
  - mem_resp_valid is ignored.
- DRAIN:
  - Discard the response on mem_resp_valid, go to IDLE.
  - Timeout also exits to IDLE.
  - flush is ignored.
- Latency: pc fire at cycle N; req_valid at N+1; with ready at N+1 and resp at N+2, inst_valid=1 at N+3. Minimum throughput is one instruction per 4 cycles.
- mem_resp_valid outside WAIT/DRAIN is ignored. Arithmetic on the timer saturates; there is no wrap.

Optional Feature:
- Macro: IFU_ALIGN_CHECK_EN.
- Defined: a pc fire with pc[1:0]≠0 issues no memory request. The next state is OUT with inst=0, inst_fault=1 and inst_pc equal to the original pc.
- Undefined: mem_req_addr = {addr_q[BITWIDTH-1:2],2'b00}; inst_pc keeps the unmodified pc; no misalignment fault.

Test Plan:
- Reset, then pc=0x80000000 fires at N; ready=1 at N+1; resp data=0x00000413 at N+2 → inst_valid=1 at N+3 with inst=0x00000413, inst_pc=0x80000000, fault=0.
- Backpressure: mem_req_ready low 3 cycles → mem_req_addr stable. inst_ready low 5 cycles → inst, inst_pc and fault stable, and pc_ready=0 throughout.
- Flush in WAIT, response 2 cycles later with data 0xDEADBEEF → never presented. Next pc=0x80000010 returns its own data.
- mem_resp_err=1 → inst_valid with inst_fault=1. TIMEOUT_CYCLES=4 with no response → OUT with inst=0, fault=1 4 cycles after acceptance.
- rst dropped to 0 in WAIT → pc_ready=1 and inst_valid=0 immediately; a stray response after release is ignored.
- pc=0x80000002: with IFU_ALIGN_CHECK_EN, no mem request and fault=1. Without it, req addr=0x80000000 and inst_pc=0x80000002.
